// File: rtl/slot_timer_if.sv
// Bundle between the time-sync block (master) and the slot scheduler (slave).
// It carries the sync inputs and the slot schedule outputs.
interface slot_timer_if #(
    parameter int P_SLOT_W = 2
);
    logic                i_enable;
    logic                i_slot_start;
    logic                i_cur_slot_id;
    logic [63:0]         i_local_time;
    logic                o_running;
    logic                o_slot_pulse;
    logic [P_SLOT_W-1:0] o_slot_id;
    logic [15:0]         o_slot_cnt;
    logic                o_guard;
    logic                o_tx_allow;
    logic [63:0]         o_slot_time;
    logic [31:0]         o_round_cnt;
    logic                o_resync_err;
    logic [15:0]         o_err_cnt;

    modport master (
        output i_enable, i_slot_start, i_cur_slot_id, i_local_time,
        input  o_running, o_slot_pulse, o_slot_id, o_slot_cnt, o_guard,
               o_tx_allow, o_slot_time, o_round_cnt, o_resync_err, o_err_cnt
    );

    modport slave (
        input  i_enable, i_slot_start, i_cur_slot_id, i_local_time,
        output o_running, o_slot_pulse, o_slot_id, o_slot_cnt, o_guard,
               o_tx_allow, o_slot_time, o_round_cnt, o_resync_err, o_err_cnt
    );
endinterface

// File: rtl/slot_timer.sv
// Free-running TDMA slot schedule, started and re-aligned by sync pulses.
// Outputs are all registered; a re-sync far from a slot boundary is flagged.
module slot_timer #(
    parameter int P_SLOT_LEN  = 1000,
    parameter int P_GUARD_LEN = 16,
    parameter int P_SLOT_NUM  = 4,
    parameter int P_SLOT_W    = 2,
    parameter int P_TOL       = 4
) (
    input logic         i_clk,
    input logic         i_rst,
    slot_timer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [15:0]         LEN16   = 16'(P_SLOT_LEN);
    localparam logic [15:0]         GUARD16 = 16'(P_GUARD_LEN);
    localparam logic [15:0]         TOL16   = 16'(P_TOL);
    localparam logic [P_SLOT_W-1:0] LAST_ID = P_SLOT_W'(P_SLOT_NUM - 1);

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [P_SLOT_W-1:0] id_q, id_d;
    logic                pulse_q, pulse_d;
    logic                guard_q, guard_d;
    logic                tx_q, tx_d;
    logic [63:0]         slot_time_q, slot_time_d;
    logic [31:0]         round_q, round_d;
    logic                resync_err_q, resync_err_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [15:0]         phase_err;

    // NOTE: every signal gets its default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        pulse_d      = 1'b0;
        slot_time_d  = slot_time_q;
        round_d      = round_q;
        resync_err_d = 1'b0;
        err_cnt_d    = err_cnt_q;
        phase_err    = (cnt_q <= LEN16 - cnt_q) ? cnt_q : LEN16 - cnt_q;

        if (!bus.i_enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            id_d    = '0;
        end else if (bus.i_slot_start) begin
            if (state_q == RUN && phase_err > TOL16) begin
                resync_err_d = 1'b1;
                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end
            // A sync always realigns, even when it lands on a natural boundary.
            state_d     = RUN;
            cnt_d       = '0;
            id_d        = P_SLOT_W'(bus.i_cur_slot_id);
            pulse_d     = 1'b1;
            slot_time_d = bus.i_local_time;
        end else if (state_q == RUN) begin
            if (cnt_q == LEN16 - 16'd1) begin
                cnt_d       = '0;
                pulse_d     = 1'b1;
                slot_time_d = bus.i_local_time;
                if (id_q == LAST_ID) begin
                    id_d    = '0;
                    round_d = round_q + 32'd1;
                end else begin
                    id_d = id_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        guard_d = (state_d == RUN) && (cnt_d < GUARD16);
        tx_d    = (state_d == RUN) && !guard_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            id_q         <= '0;
            pulse_q      <= 1'b0;
            guard_q      <= 1'b0;
            tx_q         <= 1'b0;
            slot_time_q  <= '0;
            round_q      <= '0;
            resync_err_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            pulse_q      <= pulse_d;
            guard_q      <= guard_d;
            tx_q         <= tx_d;
            slot_time_q  <= slot_time_d;
            round_q      <= round_d;
            resync_err_q <= resync_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.o_running    = (state_q == RUN);
    assign bus.o_slot_pulse = pulse_q;
    assign bus.o_slot_id    = id_q;
    assign bus.o_slot_cnt   = cnt_q;
    assign bus.o_guard      = guard_q;
    assign bus.o_tx_allow   = tx_q;
    assign bus.o_slot_time  = slot_time_q;
    assign bus.o_round_cnt  = round_q;
    assign bus.o_resync_err = resync_err_q;
    assign bus.o_err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_slot_timer.sv
// Directed bench for slot_timer with short slots (100 cycles, guard 10, tol 2).
// Local time advances by one per clock so slot_time steps are predictable.
module tb_slot_timer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    slot_timer_if #(.P_SLOT_W(2)) bus ();

    slot_timer #(
        .P_SLOT_LEN (100),
        .P_GUARD_LEN(10),
        .P_SLOT_NUM (4),
        .P_SLOT_W   (2),
        .P_TOL      (2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.i_local_time = bus.i_local_time + 64'd1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Issue a one-cycle sync pulse; returns the local time the DUT samples.
    task automatic sync(input logic id, output logic [63:0] t);
        bus.i_slot_start  = 1'b1;
        bus.i_cur_slot_id = id;
        t = bus.i_local_time;
        tick();
        bus.i_slot_start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_running"}, 64'(bus.o_running), 64'd0);
        check({tag, "_pulse"},   64'(bus.o_slot_pulse), 64'd0);
        check({tag, "_id"},      64'(bus.o_slot_id), 64'd0);
        check({tag, "_cnt"},     64'(bus.o_slot_cnt), 64'd0);
        check({tag, "_guard"},   64'(bus.o_guard), 64'd0);
        check({tag, "_tx"},      64'(bus.o_tx_allow), 64'd0);
    endtask

    logic [63:0] t_sync;
    logic [63:0] t_hold;
    logic [1:0]  exp_ids [4];
    logic        found;

    initial begin
        exp_ids[0] = 2'd2; exp_ids[1] = 2'd3; exp_ids[2] = 2'd0; exp_ids[3] = 2'd1;
        bus.i_enable      = 1'b0;
        bus.i_slot_start  = 1'b0;
        bus.i_cur_slot_id = 1'b0;
        bus.i_local_time  = 64'd0;

        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        check_idle("reset");
        check("reset_time",  bus.o_slot_time, 64'd0);
        check("reset_round", 64'(bus.o_round_cnt), 64'd0);
        check("reset_errc",  64'(bus.o_err_cnt), 64'd0);

        // Start: sync with id 1 at local time 500.
        bus.i_enable     = 1'b1;
        bus.i_local_time = 64'd500;
        sync(1'b1, t_sync);
        check("start_running", 64'(bus.o_running), 64'd1);
        check("start_pulse",   64'(bus.o_slot_pulse), 64'd1);
        check("start_id",      64'(bus.o_slot_id), 64'd1);
        check("start_cnt",     64'(bus.o_slot_cnt), 64'd0);
        check("start_time",    bus.o_slot_time, 64'd500);
        check("start_guard",   64'(bus.o_guard), 64'd1);
        check("start_tx",      64'(bus.o_tx_allow), 64'd0);
        check("start_round",   64'(bus.o_round_cnt), 64'd0);

        ticks(9);
        check("guard_cnt9",  64'(bus.o_guard), 64'd1);
        check("pulse_cnt9",  64'(bus.o_slot_pulse), 64'd0);
        tick();
        check("cnt10",       64'(bus.o_slot_cnt), 64'd10);
        check("guard_cnt10", 64'(bus.o_guard), 64'd0);
        check("tx_cnt10",    64'(bus.o_tx_allow), 64'd1);

        // Free run four slots: ids 2,3,0,1 with slot_time stepping by 100.
        ticks(89);
        check("cnt99", 64'(bus.o_slot_cnt), 64'd99);
        for (int s = 0; s < 4; s++) begin
            tick();
            check("run_pulse", 64'(bus.o_slot_pulse), 64'd1);
            check("run_cnt",   64'(bus.o_slot_cnt), 64'd0);
            check("run_id",    64'(bus.o_slot_id), 64'(exp_ids[s]));
            check("run_time",  bus.o_slot_time, 64'd600 + 64'(s) * 64'd100);
            check("run_round", 64'(bus.o_round_cnt), (s >= 2) ? 64'd1 : 64'd0);
            if (s < 3) ticks(99);
        end

        // Sync exactly on the natural wrap: id taken from sync, not incremented.
        ticks(99);
        sync(1'b0, t_sync);
        check("wrap_sync_pulse", 64'(bus.o_slot_pulse), 64'd1);
        check("wrap_sync_id",    64'(bus.o_slot_id), 64'd0);
        check("wrap_sync_cnt",   64'(bus.o_slot_cnt), 64'd0);
        check("wrap_sync_err",   64'(bus.o_resync_err), 64'd0);
        check("wrap_sync_time",  bus.o_slot_time, t_sync);
        check("wrap_sync_round", 64'(bus.o_round_cnt), 64'd1);
        tick();
        check("wrap_sync_once", 64'(bus.o_slot_pulse), 64'd0);

        // Sync at cnt=2: inside tolerance.
        tick();
        sync(1'b1, t_sync);
        check("sync2_err", 64'(bus.o_resync_err), 64'd0);
        check("sync2_id",  64'(bus.o_slot_id), 64'd1);
        check("sync2_cnt", 64'(bus.o_slot_cnt), 64'd0);

        // Sync at cnt=50: error pulse and count.
        ticks(50);
        check("pre50_cnt", 64'(bus.o_slot_cnt), 64'd50);
        sync(1'b0, t_sync);
        check("sync50_err",  64'(bus.o_resync_err), 64'd1);
        check("sync50_errc", 64'(bus.o_err_cnt), 64'd1);
        check("sync50_cnt",  64'(bus.o_slot_cnt), 64'd0);
        check("sync50_id",   64'(bus.o_slot_id), 64'd0);
        check("sync50_time", bus.o_slot_time, t_sync);
        tick();
        check("sync50_err_1cyc", 64'(bus.o_resync_err), 64'd0);

        // Boundaries of tolerance: cnt=98 (e=2) passes, cnt=3 (e=3) flags.
        ticks(97);
        sync(1'b0, t_sync);
        check("sync98_err", 64'(bus.o_resync_err), 64'd0);
        ticks(3);
        sync(1'b0, t_sync);
        check("sync3_err",  64'(bus.o_resync_err), 64'd1);
        check("sync3_errc", 64'(bus.o_err_cnt), 64'd2);

        // Sync coincident with the 3->0 wrap must not bump the round count.
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (bus.o_slot_id == 2'd3 && bus.o_slot_cnt == 16'd99) found = 1'b1;
            else tick();
        end
        check("reach_id3_cnt99", 64'(found), 64'd1);
        check("pre_wrap_round", 64'(bus.o_round_cnt), 64'd1);
        sync(1'b0, t_sync);
        check("wrap3_pulse", 64'(bus.o_slot_pulse), 64'd1);
        check("wrap3_id",    64'(bus.o_slot_id), 64'd0);
        check("wrap3_round", 64'(bus.o_round_cnt), 64'd1);
        check("wrap3_err",   64'(bus.o_resync_err), 64'd0);
        t_hold = t_sync;

        // Disable at cnt=40 together with a sync: disable wins.
        ticks(40);
        check("pre_dis_cnt", 64'(bus.o_slot_cnt), 64'd40);
        bus.i_enable = 1'b0;
        sync(1'b1, t_sync);
        check_idle("disable");
        check("disable_time",  bus.o_slot_time, t_hold);
        check("disable_round", 64'(bus.o_round_cnt), 64'd1);
        check("disable_errc",  64'(bus.o_err_cnt), 64'd2);
        sync(1'b1, t_sync);
        check_idle("idle_sync_ignored");

        // Restart, run into slot 2, reset at cnt=70.
        bus.i_enable = 1'b1;
        sync(1'b0, t_sync);
        check("restart_id", 64'(bus.o_slot_id), 64'd0);
        ticks(270);
        check("pre_rst_id",  64'(bus.o_slot_id), 64'd2);
        check("pre_rst_cnt", 64'(bus.o_slot_cnt), 64'd70);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("midrst");
        check("midrst_time",  bus.o_slot_time, 64'd0);
        check("midrst_round", 64'(bus.o_round_cnt), 64'd0);
        check("midrst_errc",  64'(bus.o_err_cnt), 64'd0);
        sync(1'b1, t_sync);
        check("post_rst_running", 64'(bus.o_running), 64'd1);
        check("post_rst_cnt",     64'(bus.o_slot_cnt), 64'd0);
        check("post_rst_id",      64'(bus.o_slot_id), 64'd1);
        check("post_rst_pulse",   64'(bus.o_slot_pulse), 64'd1);
        check("post_rst_time",    bus.o_slot_time, t_sync);
        check("post_rst_err",     64'(bus.o_resync_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
